// File: rtl/morse_code_decoder.sv
// morse_code_decoder: turns Dot/Dash/Space/EndSeq events into ASCII characters
// Optional feature macro: MORSE_DIGITS_EN (5-element digit patterns decode to '0'..'9')
// Ports:
//   clk_i           clock, all state on rising edge
//   rst_i           synchronous active-high reset
//   signals_i[2:0]  event code: 000 dot, 001 dash, 010 space, 011 end-of-sequence, 111 idle
//   char_o[7:0]     last emitted ASCII character, held until the next emission
//   char_valid_o    one-cycle pulse, char_o is new this cycle
//   seq_done_o      one-cycle pulse, end-of-sequence accepted
//   error_o         one-cycle pulse, char_o carries ERR_CHAR
module morse_code_decoder #(
   parameter logic [7:0] ERR_CHAR = 8'h3F
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] signals_i,
   output logic [7:0] char_o,
   output logic       char_valid_o,
   output logic       seq_done_o,
   output logic       error_o
);
   typedef enum logic [1:0] {IDLE, COLLECT, OVERFLOW} state_t;
   state_t     state_q, state_d;
   logic [4:0] pattern_q, pattern_d;
   logic [2:0] len_q, len_d, prev_q;
   logic [7:0] char_q, char_d;
   logic       valid_q, valid_d, done_q, done_d, err_q, err_d;
   logic       ev, is_elem, is_space, is_end, is_term;
   logic [8:0] lut;

   // Key is {length, pattern} with element n at pattern bit n (dash = 1), so
   // each code reads as the Morse string reversed; returns {error, ascii}.
   function automatic logic [8:0] lookup(input logic [2:0] l, input logic [4:0] p);
      case ({l, p})
         {3'd2, 5'b00010}: lookup = {1'b0, 8'h41};
         {3'd4, 5'b00001}: lookup = {1'b0, 8'h42};
         {3'd4, 5'b00101}: lookup = {1'b0, 8'h43};
         {3'd3, 5'b00001}: lookup = {1'b0, 8'h44};
         {3'd1, 5'b00000}: lookup = {1'b0, 8'h45};
         {3'd4, 5'b00100}: lookup = {1'b0, 8'h46};
         {3'd3, 5'b00011}: lookup = {1'b0, 8'h47};
         {3'd4, 5'b00000}: lookup = {1'b0, 8'h48};
         {3'd2, 5'b00000}: lookup = {1'b0, 8'h49};
         {3'd4, 5'b01110}: lookup = {1'b0, 8'h4A};
         {3'd3, 5'b00101}: lookup = {1'b0, 8'h4B};
         {3'd4, 5'b00010}: lookup = {1'b0, 8'h4C};
         {3'd2, 5'b00011}: lookup = {1'b0, 8'h4D};
         {3'd2, 5'b00001}: lookup = {1'b0, 8'h4E};
         {3'd3, 5'b00111}: lookup = {1'b0, 8'h4F};
         {3'd4, 5'b00110}: lookup = {1'b0, 8'h50};
         {3'd4, 5'b01011}: lookup = {1'b0, 8'h51};
         {3'd3, 5'b00010}: lookup = {1'b0, 8'h52};
         {3'd3, 5'b00000}: lookup = {1'b0, 8'h53};
         {3'd1, 5'b00001}: lookup = {1'b0, 8'h54};
         {3'd3, 5'b00100}: lookup = {1'b0, 8'h55};
         {3'd4, 5'b01000}: lookup = {1'b0, 8'h56};
         {3'd3, 5'b00110}: lookup = {1'b0, 8'h57};
         {3'd4, 5'b01001}: lookup = {1'b0, 8'h58};
         {3'd4, 5'b01101}: lookup = {1'b0, 8'h59};
         {3'd4, 5'b00011}: lookup = {1'b0, 8'h5A};
`ifdef MORSE_DIGITS_EN
         {3'd5, 5'b11111}: lookup = {1'b0, 8'h30};
         {3'd5, 5'b11110}: lookup = {1'b0, 8'h31};
         {3'd5, 5'b11100}: lookup = {1'b0, 8'h32};
         {3'd5, 5'b11000}: lookup = {1'b0, 8'h33};
         {3'd5, 5'b10000}: lookup = {1'b0, 8'h34};
         {3'd5, 5'b00000}: lookup = {1'b0, 8'h35};
         {3'd5, 5'b00001}: lookup = {1'b0, 8'h36};
         {3'd5, 5'b00011}: lookup = {1'b0, 8'h37};
         {3'd5, 5'b00111}: lookup = {1'b0, 8'h38};
         {3'd5, 5'b01111}: lookup = {1'b0, 8'h39};
`else
`endif
         default:          lookup = {1'b1, ERR_CHAR};
      endcase
   endfunction

   // Only codes 000..011 are events, and only when they differ from last cycle.
   assign ev       = !signals_i[2] && signals_i != prev_q;
   assign is_elem  = ev && !signals_i[1];
   assign is_space = ev && signals_i[1:0] == 2'b10;
   assign is_end   = ev && signals_i[1:0] == 2'b11;
   assign is_term  = is_space || is_end;
   assign lut      = lookup(len_q, pattern_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         prev_q    <= 3'b111;
         char_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         prev_q    <= signals_i;
         char_q    <= char_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      if (is_term) begin
         state_d   = IDLE;
         pattern_d = '0;
         len_d     = '0;
      end else if (is_elem && state_q != OVERFLOW) begin
         if (len_q == 3'd5) begin
            state_d = OVERFLOW;
         end else begin
            state_d   = COLLECT;
            pattern_d = pattern_q | (5'(signals_i[0]) << len_q);
            len_d     = len_q + 3'd1;
         end
      end
   end

   // EndSeq from IDLE only signals completion; every other terminator emits.
   always_comb begin
      valid_d = is_space || (is_end && state_q != IDLE);
      done_d  = is_end;
      err_d   = is_term && (state_q == OVERFLOW || (state_q == COLLECT && lut[8]));
      char_d  = !valid_d ? char_q :
                state_q == IDLE ? 8'h20 :
                state_q == OVERFLOW ? ERR_CHAR : lut[7:0];
   end

   assign char_o       = char_q;
   assign char_valid_o = valid_q;
   assign seq_done_o   = done_q;
   assign error_o      = err_q;
endmodule

// File: tb/tb_morse_code_decoder.sv
// tb_morse_code_decoder: directed checks of the Morse decoder against hand-computed outputs
module tb_morse_code_decoder;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [2:0]  signals_i = 3'b111;
   logic [7:0]  char_o;
   logic        char_valid_o, seq_done_o, error_o;
   logic [10:0] obs;
   int          n_tests = 0;
   int          n_fail = 0;

   morse_code_decoder dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .signals_i(signals_i),
      .char_o(char_o),
      .char_valid_o(char_valid_o),
      .seq_done_o(seq_done_o),
      .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   // Observed word: {char, valid, seq_done, error}
   assign obs = {char_o, char_valid_o, seq_done_o, error_o};

   task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got char=%h v/d/e=%b expected char=%h v/d/e=%b",
                  tag, got[10:3], got[2:0], exp[10:3], exp[2:0]);
      end
   endtask

   task automatic send(input logic [2:0] s);
      signals_i = s;
      @(posedge clk_i);
      #1;
   endtask

   task automatic letter(input string tag, input string m, input logic [2:0] term,
                         input logic [10:0] exp);
      for (int i = 0; i < m.len(); i++) begin
         send(m[i] == 8'h2E ? 3'b000 : 3'b001);
         send(3'b111);
      end
      send(term);
      chk(tag, obs, exp);
      send(3'b111);
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset", obs, {8'h00, 3'b000});
      rst_i = 1'b0;
      send(3'b111);
      chk("idle_after_reset", obs, {8'h00, 3'b000});

      send(3'b000);
      chk("a_dot_no_emit", obs, {8'h00, 3'b000});
      send(3'b111);
      send(3'b001);
      send(3'b111);
      send(3'b010);
      chk("a_emit", obs, {8'h41, 3'b100});
      send(3'b111);
      chk("a_pulse_one_cycle", obs, {8'h41, 3'b000});

      send(3'b010);
      chk("space_idle", obs, {8'h20, 3'b100});
      send(3'b111);
      send(3'b011);
      chk("endseq_idle", obs, {8'h20, 3'b010});
      send(3'b111);

`ifdef MORSE_DIGITS_EN
      letter("digit0_end", "-----", 3'b011, {8'h30, 3'b110});
      letter("digit5", ".....", 3'b010, {8'h35, 3'b100});
`else
      letter("digit0_end", "-----", 3'b011, {8'h3F, 3'b111});
      letter("digit5", ".....", 3'b010, {8'h3F, 3'b101});
`endif

      letter("overflow_space", "......", 3'b010, {8'h3F, 3'b101});
      letter("t_after_overflow", "-", 3'b010, {8'h54, 3'b100});
      letter("overflow_end", "-------", 3'b011, {8'h3F, 3'b111});
      letter("unlisted", "..--", 3'b010, {8'h3F, 3'b101});

      letter("e", ".", 3'b010, {8'h45, 3'b100});
      letter("n", "-.", 3'b010, {8'h4E, 3'b100});
      letter("k_end", "-.-", 3'b011, {8'h4B, 3'b110});
      letter("q", "--.-", 3'b010, {8'h51, 3'b100});
      letter("y", "-.--", 3'b010, {8'h59, 3'b100});
      letter("z", "--..", 3'b010, {8'h5A, 3'b100});
      letter("j", ".---", 3'b010, {8'h4A, 3'b100});
      letter("x", "-..-", 3'b010, {8'h58, 3'b100});
      letter("c", "-.-.", 3'b010, {8'h43, 3'b100});

      send(3'b000);
      send(3'b111);
      send(3'b000);
      rst_i = 1'b1;
      signals_i = 3'b001;
      @(posedge clk_i);
      #1;
      chk("reset_mid_letter", obs, {8'h00, 3'b000});
      rst_i = 1'b0;
      send(3'b001);
      chk("held_dash_after_reset", obs, {8'h00, 3'b000});
      send(3'b010);
      chk("t_after_reset", obs, {8'h54, 3'b100});
      send(3'b111);

      repeat (10) send(3'b000);
      send(3'b001);
      send(3'b010);
      chk("held_dot_a", obs, {8'h41, 3'b100});
      send(3'b011);
      chk("b2b_endseq", obs, {8'h41, 3'b010});
      send(3'b010);
      chk("b2b_space", obs, {8'h20, 3'b100});
      send(3'b111);

      send(3'b000);
      send(3'b101);
      send(3'b010);
      chk("reserved_ignored", obs, {8'h45, 3'b100});
      send(3'b111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/morse_code_decoder.md
MORSE_CODE_DECODER -- requirements
Module: morse_code_decoder

Interface
REQ-001 Parameter ERR_CHAR, default 8'h3F ('?'), ASCII code emitted for an undecodable or overlong letter.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset; synchronous, active-high.
REQ-004 Signals  input  3  Morse event code: 000 Dot, 001 Dash, 010 Space, 011 EndSeq, 111 idle; 100-110 reserved.
REQ-005 Char  output  8  ASCII of the last decoded character; holds until the next emission.
REQ-006 CharValid  output  1  one-cycle pulse; Char is new this cycle.
REQ-007 SeqDone  output  1  one-cycle pulse; EndSeq accepted.
REQ-008 Error  output  1  one-cycle pulse; coincident with CharValid when Char=ERR_CHAR.

Function
REQ-009 Register PrevSignals (reset 3'b111); event on an edge where Signals != PrevSignals and Signals is not 111 or reserved; PrevSignals <= Signals every cycle.
REQ-010 A held code is one event; a direct code-to-code change (e.g. 000->001) is a new event; reserved codes are never events.
REQ-011 Letter buffer: Pattern[4:0] and Len[2:0]; element n (0-based) stored at Pattern[n], Dot=0, Dash=1.
REQ-012 States: IDLE (Len=0), COLLECT (Len 1..5), OVERFLOW (sixth element received).
REQ-013 Dot/Dash in IDLE or COLLECT with Len<5: store element, Len+1, state COLLECT.
REQ-014 Dot/Dash with Len=5: state OVERFLOW; further Dot/Dash in OVERFLOW discarded.
REQ-015 Space in COLLECT: look up Pattern/Len, emit Char, CharValid=1; clear buffer; go IDLE.
REQ-016 Space in IDLE: emit Char=8'h20 (word gap), CharValid=1.
REQ-017 Space or EndSeq in OVERFLOW: emit ERR_CHAR with CharValid=1, Error=1; clear buffer; go IDLE.
REQ-018 EndSeq in COLLECT: emit letter as REQ-015 and SeqDone=1 in the same cycle; go IDLE.
REQ-019 EndSeq in IDLE: SeqDone=1 only; no CharValid.
REQ-020 Lookup: standard International Morse A-Z to uppercase ASCII 0x41-0x5A; unlisted pattern/length pair -> ERR_CHAR with Error=1.
REQ-021 Latency: outputs register on the same clock edge that samples the terminating event and are visible for exactly the next cycle; pulses are never stretched.
REQ-022 Back-to-back terminators on consecutive cycles each emit independently.

Reset
REQ-023 Reset, from any state and mid-letter, SHALL set state IDLE, Pattern=0, Len=0, PrevSignals=111, Char=8'h00, CharValid=0, SeqDone=0, Error=0.
REQ-024 Reset has priority over any event on the same edge; the sampled event is discarded.
REQ-025 On the first cycle after Reset deasserts, a code already held on Signals counts as a new event.

Configuration
REQ-026 Macro MORSE_DIGITS_EN defined: 5-element digit patterns decode to ASCII '0'-'9' (0x30-0x39).
REQ-027 MORSE_DIGITS_EN undefined: 5-element digit patterns decode to ERR_CHAR with Error=1; letter behaviour is unchanged.

Verification
REQ-028 Dot, idle, Dash, idle, Space -> one cycle with Char=0x41, CharValid=1, Error=0.
REQ-029 Space from IDLE -> Char=0x20, CharValid=1; then EndSeq from IDLE -> SeqDone=1, CharValid=0.
REQ-030 Five Dashes then EndSeq -> with MORSE_DIGITS_EN: Char=0x30, CharValid=1, SeqDone=1 in the same cycle; without it: Char=0x3F, Error=1, SeqDone=1.
REQ-031 Six Dots then Space -> Char=0x3F, CharValid=1, Error=1; next Dash, Space -> Char=0x54.
REQ-032 Dot, Dot, then Reset for one cycle, then Dash, Space -> Char=0x54 only; no emission for the pre-reset elements.
REQ-033 Signals held 000 for 10 cycles, then 001, then 010 with no idle in between -> Char=0x41 ('A', exactly one Dot counted).
